// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial adder link: collector state encoding and default width.
package serial_link_pkg;

    localparam int SER_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CARRY   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/serial_sum_collector_if.sv
// Serial link bundle between the bit-serial adder side (master) and the result collector (slave).
interface serial_sum_collector_if #(parameter int N = serial_link_pkg::SER_W);

    logic         start;
    logic         bit_valid;
    logic         s_in;
    logic         c_in;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, bit_valid, s_in, c_in,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, bit_valid, s_in, c_in,
        output sum, cout, ovf, busy, done
    );

endinterface

// File: rtl/serial_shift_reg.sv
// N-bit LSB-first shift-in register: each enabled cycle the new bit enters at the MSB end.
module serial_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         d_in,
    output logic [N-1:0] q
);

    logic [N-1:0] shift_q;
    logic [N-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (en) begin
            shift_d = {d_in, shift_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_sum_collector.sv
// Receive end of the bit-serial adder: assembles the parallel sum, final carry and signed overflow.
//   state     | meaning
//   S_IDLE    | waiting for start, serial bits ignored
//   S_COLLECT | shifting in N sum bits, stalls while bit_valid is low
//   S_CARRY   | sampling the adder carry after the MSB into cout/ovf
//   S_DONE    | one-cycle result-valid pulse
module serial_sum_collector
    import serial_link_pkg::*;
#(
    parameter int N = SER_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_sum_collector_if.slave  bus
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_msb_q, c_msb_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          shift_en;
    logic [N-1:0]  sum_w;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        c_msb_d  = c_msb_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        shift_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                // start takes priority over a bit in the same cycle: restart the word
                if (bus.start) begin
                    cnt_d = '0;
                end else if (bus.bit_valid) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        c_msb_d = bus.c_in;
                        state_d = S_CARRY;
                    end
                end
            end
            S_CARRY: begin
                if (bus.start) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end else begin
                    cout_d  = bus.c_in;
                    ovf_d   = c_msb_q ^ bus.c_in;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_COLLECT) || (state_d == S_CARRY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    serial_shift_reg #(.N(N)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .d_in  (bus.s_in),
        .q     (sum_w)
    );

    assign bus.sum  = sum_w;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Self-checking bench for serial_sum_collector driven by a behavioural bit-serial adder.
module tb_serial_sum_collector;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        int           stall_at;
        int           stall_len;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   dpulse;
    int   bcnt;

    serial_sum_collector_if #(.N(N)) bus ();

    serial_sum_collector #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) dpulse++;
        if (bus.busy === 1'b1) bcnt++;
    endtask

    // Sum bit i of a+b+cin
    function automatic logic sbit(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input int i);
        int full;
        full = int'(a) + int'(b) + int'(cin);
        return 1'((full >> i) & 1);
    endfunction

    // Carry into bit position i (i == N gives the final carry-out)
    function automatic logic cbit(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input int i);
        int mask;
        int low;
        mask = (1 << i) - 1;
        low  = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
        return 1'((low >> i) & 1);
    endfunction

    // Reference: unsigned sum/carry from integer addition, overflow from signed range
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         output logic [N-1:0] s, output logic co, output logic ov);
        int full;
        int sfull;
        int sa;
        int sb;
        full  = int'(a) + int'(b) + int'(cin);
        s     = N'(full % (1 << N));
        co    = (full >= (1 << N));
        sa    = int'(a) - ((int'(a) >= (1 << (N - 1))) ? (1 << N) : 0);
        sb    = int'(b) - ((int'(b) >= (1 << (N - 1))) ? (1 << N) : 0);
        sfull = sa + sb + int'(cin);
        ov    = (sfull > (1 << (N - 1)) - 1) || (sfull < -(1 << (N - 1)));
    endtask

    task automatic run_word(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                            input int stall_at, input int stall_len,
                            input logic [N-1:0] exp_sum, input logic exp_cout,
                            input logic exp_ovf, input string tag);
        int d0;
        int b0;
        int stalls;
        d0     = dpulse;
        b0     = bcnt;
        stalls = (stall_at >= 0) ? stall_len : 0;
        bus.start     = 1'b1;
        bus.bit_valid = 1'($urandom);
        bus.s_in      = 1'($urandom);
        bus.c_in      = cin;
        tick();
        chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    bus.bit_valid = 1'b0;
                    bus.s_in      = 1'($urandom);
                    bus.c_in      = cbit(a, b, cin, i);
                    tick();
                end
            end
            bus.bit_valid = 1'b1;
            bus.s_in      = sbit(a, b, cin, i);
            bus.c_in      = cbit(a, b, cin, i);
            tick();
        end
        chk({tag, "_done_in_carry"}, 32'(bus.done), 32'd0);
        // bits arriving after the MSB must be ignored
        bus.bit_valid = 1'($urandom);
        bus.s_in      = 1'($urandom);
        bus.c_in      = cbit(a, b, cin, N);
        tick();
        bus.bit_valid = 1'b0;
        bus.c_in      = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_done_count"}, 32'(dpulse - d0), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(bcnt - b0), 32'(N + 1 + stalls));
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sum"}, 32'(bus.sum), 32'd0);
        chk({tag, "_cout"}, 32'(bus.cout), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        logic [N-1:0] ra, rb, es;
        logic         rc, ec, eo;
        int           d0, sat, slen;

        checks = 0;
        errors = 0;
        dpulse = 0;
        bcnt   = 0;

        vecs[0] = '{a: 4'd5,  b: 4'd3, cin: 1'b0, stall_at: -1, stall_len: 0,
                    exp_sum: 4'b1000, exp_cout: 1'b0, exp_ovf: 1'b1};
        vecs[1] = '{a: 4'd15, b: 4'd1, cin: 1'b0, stall_at: -1, stall_len: 0,
                    exp_sum: 4'b0000, exp_cout: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd0, cin: 1'b1, stall_at: -1, stall_len: 0,
                    exp_sum: 4'b1000, exp_cout: 1'b0, exp_ovf: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd0, cin: 1'b0, stall_at: -1, stall_len: 0,
                    exp_sum: 4'b0000, exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[4] = '{a: 4'd6,  b: 4'd5, cin: 1'b0, stall_at: 2,  stall_len: 3,
                    exp_sum: 4'b1011, exp_cout: 1'b0, exp_ovf: 1'b1};
        vecs[5] = '{a: 4'd2,  b: 4'd2, cin: 1'b0, stall_at: -1, stall_len: 0,
                    exp_sum: 4'b0100, exp_cout: 1'b0, exp_ovf: 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.s_in      = 1'b0;
        bus.c_in      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // bits offered while idle must not disturb anything
        bus.bit_valid = 1'b1;
        bus.s_in      = 1'b1;
        tick();
        tick();
        bus.bit_valid = 1'b0;
        check_zero("idle_bits");

        for (int v = 0; v < 6; v++) begin
            run_word(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].stall_at, vecs[v].stall_len,
                     vecs[v].exp_sum, vecs[v].exp_cout, vecs[v].exp_ovf, $sformatf("vec%0d", v));
            tick();
            chk($sformatf("vec%0d_done_single", v), 32'(bus.done), 32'd0);
            chk($sformatf("vec%0d_sum_hold", v), 32'(bus.sum), 32'(vecs[v].exp_sum));
        end

        // abort 9+9 after bit 2, then 2+2 completes with a single done
        d0 = dpulse;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1'b1;
            bus.s_in      = sbit(4'd9, 4'd9, 1'b0, i);
            bus.c_in      = cbit(4'd9, 4'd9, 1'b0, i);
            tick();
        end
        run_word(4'd2, 4'd2, 1'b0, -1, 0, 4'b0100, 1'b0, 1'b0, "abort");
        chk("abort_total_done", 32'(dpulse - d0), 32'd1);
        tick();

        // async reset mid-COLLECT after a word that left nonzero flags
        run_word(4'd5, 4'd3, 1'b0, -1, 0, 4'b1000, 1'b0, 1'b1, "pre_rst");
        d0 = dpulse;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bit_valid = 1'b1;
            bus.s_in      = 1'b1;
            bus.c_in      = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        rst_n = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        tick();
        bus.bit_valid = 1'b0;
        chk("rst_no_done", 32'(dpulse - d0), 32'd0);
        check_zero("post_rst_idle");
        run_word(4'd15, 4'd1, 1'b0, -1, 0, 4'b0000, 1'b1, 1'b0, "post_rst");

        // randomized words against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            ra   = N'($urandom);
            rb   = N'($urandom);
            rc   = 1'($urandom);
            sat  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(N - 1, 0)) : -1;
            slen = int'($urandom_range(3, 1));
            model(ra, rb, rc, es, ec, eo);
            run_word(ra, rb, rc, sat, slen, es, ec, eo, $sformatf("rnd%0d", n));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                bus.bit_valid = 1'($urandom);
                bus.s_in      = 1'($urandom);
                tick();
            end
            bus.bit_valid = 1'b0;
            chk($sformatf("rnd%0d_hold", n), 32'(bus.sum), 32'(es));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
